// File: rtl/conv3x3_mac_if.sv
// conv3x3_mac_if: bus bundle for the 3x3 convolution MAC engine.
//
// Groups the window input stream, the configuration write port and the
// result output stream so that the engine and its environment connect with a
// single port each.
//
// Signals:
//   pixel_data        9*DATA_W  packed window, tap k (row-major) at [k*DATA_W +: DATA_W]
//   pixel_data_valid  1         window valid
//   pixel_data_ready  1         engine accepts window this cycle
//   cfg_we            1         config write strobe
//   cfg_addr          4         0-8 kernel tap, 9 norm_mul, 10 shift, 11 abs mode
//   cfg_data          16        config write data (low bits used)
//   o_pixel           DATA_W    result pixel
//   o_pixel_valid     1         result valid
//   o_pixel_ready     1         downstream accepts result
//
// Modports:
//   slave   engine side
//   master  source/sink side (pipeline neighbour or testbench)

interface conv3x3_mac_if #(
    parameter int DATA_W = 8
);

    logic [9*DATA_W-1:0] pixel_data;
    logic                pixel_data_valid;
    logic                pixel_data_ready;

    logic                cfg_we;
    logic [3:0]          cfg_addr;
    logic [15:0]         cfg_data;

    logic [DATA_W-1:0]   o_pixel;
    logic                o_pixel_valid;
    logic                o_pixel_ready;

    modport slave (
        input  pixel_data,
        input  pixel_data_valid,
        output pixel_data_ready,
        input  cfg_we,
        input  cfg_addr,
        input  cfg_data,
        output o_pixel,
        output o_pixel_valid,
        input  o_pixel_ready
    );

    modport master (
        output pixel_data,
        output pixel_data_valid,
        input  pixel_data_ready,
        output cfg_we,
        output cfg_addr,
        output cfg_data,
        input  o_pixel,
        input  o_pixel_valid,
        output o_pixel_ready
    );

endinterface

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3x3 convolution multiply-accumulate engine.
//
// Consumes one packed 3x3 window per transfer and produces one normalised,
// saturated pixel four cycles later. Coefficients are signed and writable at
// runtime; normalisation is (sum * norm_mul) >>> shift, optionally followed
// by absolute value, then clamped to [0, 2^DATA_W-1].
//
// Pipeline:
//   S1  tap products           (prod_q)
//   S2  9-input adder tree     (sum_q)
//   S3  reciprocal multiply    (mul_q)
//   S4  shift / abs / saturate (o_pixel)
// All stages advance together when the output register is empty or being
// drained, so the window-side ready is simply that advance enable.
//
// Ports:
//   clk   clock, all state on rising edge
//   rstn  asynchronous active-low reset
//   bus   conv3x3_mac_if.slave (window in, config write, result out)
//
// Build option:
//   CONV_ROUND_EN  when defined, S4 adds 2^(shift-1) before the shift
//                  (round half up on the signed value); otherwise the shift
//                  truncates toward -inf. Latency is the same either way.
//
// The interface DATA_W parameter must match this module's DATA_W.

module conv3x3_mac #(
    parameter int DATA_W  = 8,
    parameter int COEF_W  = 8,
    parameter int NORM_W  = 10,
    parameter int SHIFT_W = 5
) (
    input logic          clk,
    input logic          rstn,
    conv3x3_mac_if.slave bus
);

    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SUM_W  = DATA_W + COEF_W + 5;
    localparam int MUL_W  = SUM_W + NORM_W + 1;
    // One spare bit so the rounding increment can never wrap the product.
    localparam int RND_W  = MUL_W + 1;

    localparam int NTAPS  = 9;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0]  kernel_q   [NTAPS];
    logic signed [COEF_W-1:0]  kernel_d   [NTAPS];
    logic        [NORM_W-1:0]  norm_mul_q;
    logic        [NORM_W-1:0]  norm_mul_d;
    logic        [SHIFT_W-1:0] shift_q;
    logic        [SHIFT_W-1:0] shift_d;
    logic                      abs_mode_q;
    logic                      abs_mode_d;

    // Writes land on the next edge independent of the pipeline enable; a
    // window accepted on that same edge therefore still sees the old kernel.
    always_comb begin
        kernel_d   = kernel_q;
        norm_mul_d = norm_mul_q;
        shift_d    = shift_q;
        abs_mode_d = abs_mode_q;
        if (bus.cfg_we) begin
            for (int k = 0; k < NTAPS; k++) begin
                if (bus.cfg_addr == 4'(k)) begin
                    kernel_d[k] = bus.cfg_data[COEF_W-1:0];
                end
            end
            case (bus.cfg_addr)
                4'd9:    norm_mul_d = bus.cfg_data[NORM_W-1:0];
                4'd10:   shift_d    = bus.cfg_data[SHIFT_W-1:0];
                4'd11:   abs_mode_d = bus.cfg_data[0];
                default: ;  // taps handled above, 12-15 ignored
            endcase
        end
    end

    // Defaults form a 9-tap box blur: 57/512 is roughly 1/9.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAPS; k++) begin
                kernel_q[k] <= COEF_W'(1);
            end
            norm_mul_q <= NORM_W'(57);
            shift_q    <= SHIFT_W'(9);
            abs_mode_q <= 1'b0;
        end else begin
            kernel_q   <= kernel_d;
            norm_mul_q <= norm_mul_d;
            shift_q    <= shift_d;
            abs_mode_q <= abs_mode_d;
        end
    end

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic              en;
    logic              s1_valid_q;
    logic              s2_valid_q;
    logic              s3_valid_q;
    logic              o_pixel_valid_q;
    logic [DATA_W-1:0] o_pixel_q;

    // The whole pipe moves as one; only the output register can block it.
    assign en = !o_pixel_valid_q || bus.o_pixel_ready;

    assign bus.pixel_data_ready = en;
    assign bus.o_pixel          = o_pixel_q;
    assign bus.o_pixel_valid    = o_pixel_valid_q;

    // ------------------------------------------------------------------
    // S1: tap products
    // ------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_d [NTAPS];
    logic signed [PROD_W-1:0] prod_q [NTAPS];

    // Pixels are unsigned: a zero MSB is prepended so the signed multiply
    // treats them as non-negative.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod_d[k] = PROD_W'(signed'({1'b0, bus.pixel_data[k*DATA_W +: DATA_W]}))
                      * PROD_W'(kernel_q[k]);
        end
    end

    // ------------------------------------------------------------------
    // S2: adder tree
    // ------------------------------------------------------------------
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;

    // Four guard bits above the product width cover the nine-way sum.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum_d = sum_d + SUM_W'(prod_q[k]);
        end
    end

    // ------------------------------------------------------------------
    // S3: reciprocal multiply
    // ------------------------------------------------------------------
    logic signed [MUL_W-1:0] mul_d;
    logic signed [MUL_W-1:0] mul_q;

    always_comb begin
        mul_d = MUL_W'(sum_q) * MUL_W'(signed'({1'b0, norm_mul_q}));
    end

    // ------------------------------------------------------------------
    // S4: shift, optional rounding, abs, saturate
    // ------------------------------------------------------------------
    logic signed [RND_W-1:0] rnd;
    logic signed [RND_W-1:0] shifted;
    logic signed [RND_W-1:0] mag;
    logic        [DATA_W-1:0] pix_d;

    always_comb begin
        rnd = RND_W'(mul_q);
`ifdef CONV_ROUND_EN
        // Half-LSB bias ahead of the floor shift gives round-half-up.
        if (shift_q != '0) begin
            rnd = rnd + (RND_W'(1) << (shift_q - SHIFT_W'(1)));
        end
`endif
        shifted = rnd >>> shift_q;

        mag = shifted;
        if (abs_mode_q && shifted[RND_W-1]) begin
            mag = -shifted;
        end

        if (mag[RND_W-1]) begin
            pix_d = '0;
        end else if (|mag[RND_W-2:DATA_W]) begin
            pix_d = '1;
        end else begin
            pix_d = mag[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    // Valid bits and the visible output are reset; o_pixel only loads on a
    // real result so it holds its last value across bubbles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q      <= 1'b0;
            s2_valid_q      <= 1'b0;
            s3_valid_q      <= 1'b0;
            o_pixel_valid_q <= 1'b0;
            o_pixel_q       <= '0;
        end else if (en) begin
            s1_valid_q      <= bus.pixel_data_valid;
            s2_valid_q      <= s1_valid_q;
            s3_valid_q      <= s2_valid_q;
            o_pixel_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                o_pixel_q <= pix_d;
            end
        end
    end

    // Datapath registers carry don't-care values in bubbles, so no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_q <= prod_d;
            sum_q  <= sum_d;
            mul_q  <= mul_d;
        end
    end

endmodule
